// File: rtl/uart_program_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_program_loader_pkg
//  Purpose  : Shared constants and state encodings for the UART program
//             loader and its serial receiver.
//  Revision : 1.0 - initial release
// ============================================================================
package uart_program_loader_pkg;

    // Frame constants
    localparam logic [7:0] SYNC_BYTE  = 8'hA5;
    localparam int         WORD_BYTES = 4;

    // Loader FSM encoding
    localparam int         LDR_STATE_W = 3;
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LEN0  = 3'd1;
    localparam logic [2:0] ST_LEN1  = 3'd2;
    localparam logic [2:0] ST_DATA  = 3'd3;
    localparam logic [2:0] ST_CHECK = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;
    localparam logic [2:0] ST_ERROR = 3'd6;

    // Receiver FSM encoding
    localparam int         RX_STATE_W = 2;
    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

endpackage : uart_program_loader_pkg
`default_nettype wire

// File: rtl/uart_program_loader_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_program_loader_uart_rx
//  Purpose  : 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling,
//             one-cycle byte_valid / frame_err pulses at the stop-bit centre.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_program_loader_uart_rx
    import uart_program_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_rx,
    output logic [7:0] o_rx_data,
    output logic       o_byte_valid,
    output logic       o_frame_err
);

    localparam int                 c_CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_HALF  = c_CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    logic                  r_sync1;
    logic                  r_sync2;
    logic [RX_STATE_W-1:0] r_state;
    logic [RX_STATE_W-1:0] w_next_state;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [2:0]            r_bit;
    logic [7:0]            r_shift;
    logic                  w_cnt_done;

    // The start bit is re-checked after half a bit; every later bit after a full bit
    assign w_cnt_done = (r_state == RX_START) ? (r_cnt == c_HALF) : (r_cnt == c_FULL);

    // Two-flop synchroniser for the asynchronous line, reset to the idle level
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_rx;
            r_sync2 <= r_sync1;
        end
    end

    // Receiver state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RX_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Receiver next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            RX_IDLE:  if (!r_sync2) w_next_state = RX_START;
            RX_START: if (w_cnt_done) w_next_state = r_sync2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (w_cnt_done && (r_bit == 3'd7)) w_next_state = RX_STOP;
            RX_STOP:  if (w_cnt_done) w_next_state = RX_IDLE;
            default:  w_next_state = RX_IDLE;
        endcase
    end

    // Bit-timing counter, bit index and LSB-first shift register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            if ((r_state == RX_IDLE) || w_cnt_done) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + c_ONE;
            end
            if (r_state == RX_START) begin
                r_bit <= '0;
            end else if ((r_state == RX_DATA) && w_cnt_done) begin
                r_shift <= {r_sync2, r_shift[7:1]};
                r_bit   <= r_bit + 3'd1;
            end
        end
    end

    // Output decode: verdict on the stop bit at its centre
    always_comb begin
        o_rx_data    = r_shift;
        o_byte_valid = (r_state == RX_STOP) && w_cnt_done && r_sync2;
        o_frame_err  = (r_state == RX_STOP) && w_cnt_done && !r_sync2;
    end

endmodule : uart_program_loader_uart_rx
`default_nettype wire

// File: rtl/uart_program_loader.sv
`default_nettype none
// ============================================================================
//  Module   : uart_program_loader
//  Purpose  : Receives a framed program image over UART, writes it word by
//             word into program memory, verifies an XOR checksum and holds
//             the CPU in reset until the image is accepted.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_program_loader
    import uart_program_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT    = 868,
    parameter int PMEM_ADDR_WIDTH = 12,
    parameter int TIMEOUT_CYCLES  = 1_000_000
) (
    input  logic                       sysclk,
    input  logic                       rst,
    input  logic                       uart_rx,
    output logic [PMEM_ADDR_WIDTH-1:0] pmem_wr_addr,
    output logic [31:0]                pmem_wr_data,
    output logic [3:0]                 pmem_byte_w_en,
    output logic                       cpu_rst,
    output logic                       load_done,
    output logic                       load_error
);

    localparam int                         c_TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TMO_W-1:0]         c_TMO_LAST  = c_TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_TMO_W-1:0]         c_TMO_ONE   = c_TMO_W'(1);
    localparam logic [PMEM_ADDR_WIDTH:0]   c_WCNT_ONE  = (PMEM_ADDR_WIDTH + 1)'(1);
    localparam logic [16:0]                c_MAX_WORDS = 17'(1) << PMEM_ADDR_WIDTH;
    localparam logic [1:0]                 c_LAST_LANE = 2'(WORD_BYTES - 1);

    logic [7:0]                 w_rx_data;
    logic                       w_byte_valid;
    logic                       w_frame_err;

    logic [LDR_STATE_W-1:0]     r_state;
    logic [LDR_STATE_W-1:0]     w_next_state;
    logic [15:0]                r_len;
    // One bit wider than the address so a full-memory image never wraps
    logic [PMEM_ADDR_WIDTH:0]   r_wcnt;
    logic [31:0]                r_word;
    logic [1:0]                 r_byte_idx;
    logic [7:0]                 r_csum;
    logic                       r_wr_pend;
    logic                       r_err;
    logic [c_TMO_W-1:0]         r_tmo;

    logic                       w_sync;
    logic [15:0]                w_len_full;
    logic [16:0]                w_words_next;
    logic                       w_tmo_active;
    logic                       w_timeout;

    uart_program_loader_uart_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk          (sysclk),
        .rst          (rst),
        .i_rx         (uart_rx),
        .o_rx_data    (w_rx_data),
        .o_byte_valid (w_byte_valid),
        .o_frame_err  (w_frame_err)
    );

    assign w_sync       = w_byte_valid && (w_rx_data == SYNC_BYTE);
    assign w_len_full   = {w_rx_data, r_len[7:0]};
    assign w_words_next = 17'(r_wcnt) + 17'd1;
    assign w_tmo_active = (r_state == ST_LEN0) || (r_state == ST_LEN1) ||
                          (r_state == ST_DATA) || (r_state == ST_CHECK);
    assign w_timeout    = w_tmo_active && (r_tmo == c_TMO_LAST);

    // Loader state register
    always_ff @(posedge sysclk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Loader next-state logic; line faults and silence abort an open frame
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (w_sync) w_next_state = ST_LEN0;
            end
            ST_LEN0: begin
                if (w_byte_valid) w_next_state = ST_LEN1;
            end
            ST_LEN1: begin
                if (w_byte_valid) begin
                    if (17'(w_len_full) > c_MAX_WORDS) begin
                        w_next_state = ST_ERROR;
                    end else if (w_len_full == 16'd0) begin
                        w_next_state = ST_CHECK;
                    end else begin
                        w_next_state = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (w_byte_valid && (r_byte_idx == c_LAST_LANE) &&
                    (w_words_next == 17'(r_len))) begin
                    w_next_state = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (w_byte_valid) begin
                    w_next_state = (w_rx_data == r_csum) ? ST_DONE : ST_ERROR;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
        if (w_tmo_active && (w_frame_err || w_timeout)) begin
            w_next_state = ST_ERROR;
        end
    end

    // Frame datapath: length capture, word assembly, checksum, write strobe, timeout
    always_ff @(posedge sysclk) begin
        if (rst) begin
            r_len      <= '0;
            r_wcnt     <= '0;
            r_word     <= '0;
            r_byte_idx <= '0;
            r_csum     <= '0;
            r_wr_pend  <= 1'b0;
            r_err      <= 1'b0;
            r_tmo      <= '0;
        end else begin
            r_wr_pend <= 1'b0;
            // Address advances the cycle after its strobe
            if (r_wr_pend) begin
                r_wcnt <= r_wcnt + c_WCNT_ONE;
            end
            if (w_byte_valid) begin
                case (r_state)
                    ST_IDLE, ST_DONE, ST_ERROR: begin
                        if (w_rx_data == SYNC_BYTE) begin
                            r_wcnt     <= '0;
                            r_byte_idx <= '0;
                            r_csum     <= '0;
                            r_err      <= 1'b0;
                        end
                    end
                    ST_LEN0: r_len[7:0]  <= w_rx_data;
                    ST_LEN1: r_len[15:8] <= w_rx_data;
                    ST_DATA: begin
                        r_word[8*r_byte_idx +: 8] <= w_rx_data;
                        r_csum                    <= r_csum ^ w_rx_data;
                        r_byte_idx                <= r_byte_idx + 2'd1;
                        if (r_byte_idx == c_LAST_LANE) begin
                            r_wr_pend <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            if ((w_next_state == ST_ERROR) && (r_state != ST_ERROR)) begin
                r_err <= 1'b1;
            end
            if (!w_tmo_active || w_byte_valid) begin
                r_tmo <= '0;
            end else begin
                r_tmo <= r_tmo + c_TMO_ONE;
            end
        end
    end

    // Output decode
    always_comb begin
        cpu_rst        = (r_state != ST_DONE);
        load_done      = (r_state == ST_DONE);
        load_error     = r_err;
        pmem_byte_w_en = r_wr_pend ? 4'b1111 : 4'b0000;
        pmem_wr_addr   = r_wcnt[PMEM_ADDR_WIDTH-1:0];
        pmem_wr_data   = r_word;
    end

endmodule : uart_program_loader
`default_nettype wire

// File: tb/tb_uart_program_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_program_loader
//  Purpose  : Self-checking bench for uart_program_loader: table of frames,
//             hand-written corner sequences and random frames checked
//             against a frame-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_program_loader;

    localparam int CPB = 8;
    localparam int AW  = 12;
    localparam int TMO = 3000;

    logic          sysclk = 1'b0;
    logic          rst    = 1'b1;
    logic          uart_rx = 1'b1;
    logic [AW-1:0] pmem_wr_addr;
    logic [31:0]   pmem_wr_data;
    logic [3:0]    pmem_byte_w_en;
    logic          cpu_rst;
    logic          load_done;
    logic          load_error;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic [AW-1:0] a;
        logic [31:0]   d;
    } wr_t;
    wr_t wq[$];

    typedef struct {
        int         n;
        logic [7:0] b [12];
        int         nw;
        logic [31:0] w [2];
        logic       done;
        logic       err;
    } vec_t;
    vec_t vecs [5];

    uart_program_loader #(
        .CLKS_PER_BIT    (CPB),
        .PMEM_ADDR_WIDTH (AW),
        .TIMEOUT_CYCLES  (TMO)
    ) dut (
        .sysclk         (sysclk),
        .rst            (rst),
        .uart_rx        (uart_rx),
        .pmem_wr_addr   (pmem_wr_addr),
        .pmem_wr_data   (pmem_wr_data),
        .pmem_byte_w_en (pmem_byte_w_en),
        .cpu_rst        (cpu_rst),
        .load_done      (load_done),
        .load_error     (load_error)
    );

    always #5 sysclk = ~sysclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Write-port monitor: records every strobe, checks its value and width
    logic prev_en = 1'b0;
    always @(negedge sysclk) begin
        if (pmem_byte_w_en !== 4'h0) begin
            chk("strobe_value", {28'd0, pmem_byte_w_en}, 32'hF);
            chk("strobe_one_cycle", {31'd0, prev_en}, 32'd0);
            wq.push_back('{a: pmem_wr_addr, d: pmem_wr_data});
        end
        prev_en = (pmem_byte_w_en !== 4'h0);
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        @(negedge sysclk);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge sysclk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge sysclk);
        end
        uart_rx = stop_ok;
        repeat (CPB) @(negedge sysclk);
        uart_rx = 1'b1;
        repeat (2 * CPB) @(negedge sysclk);
    endtask

    task automatic check_status(input string tag, input logic done, input logic err);
        chk({tag, "_load_done"}, {31'd0, load_done}, {31'd0, done});
        chk({tag, "_load_error"}, {31'd0, load_error}, {31'd0, err});
        chk({tag, "_cpu_rst"}, {31'd0, cpu_rst}, {31'd0, ~done});
    endtask

    task automatic check_reset_outputs(input string tag);
        check_status(tag, 1'b0, 1'b0);
        chk({tag, "_w_en"}, {28'd0, pmem_byte_w_en}, 32'd0);
        chk({tag, "_addr"}, {20'd0, pmem_wr_addr}, 32'd0);
        chk({tag, "_data"}, pmem_wr_data, 32'd0);
    endtask

    // Compare captured writes against an expected word list stored at 0..n-1
    task automatic check_writes(input string tag, input logic [31:0] exp_w[$]);
        chk({tag, "_nwrites"}, wq.size(), exp_w.size());
        for (int i = 0; i < exp_w.size() && i < wq.size(); i++) begin
            chk({tag, "_waddr"}, {20'd0, wq[i].a}, i);
            chk({tag, "_wdata"}, wq[i].d, exp_w[i]);
        end
        wq.delete();
    endtask

    initial begin
        logic [31:0] exp_w[$];
        logic [7:0]  fq[$];
        logic [7:0]  cs;

        vecs[0].n = 12; vecs[0].nw = 2; vecs[0].done = 1'b1; vecs[0].err = 1'b0;
        vecs[0].b = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
        vecs[0].w = '{32'h0000_0013, 32'h0010_0093};
        vecs[1].n = 12; vecs[1].nw = 2; vecs[1].done = 1'b0; vecs[1].err = 1'b1;
        vecs[1].b = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h91};
        vecs[1].w = '{32'h0000_0013, 32'h0010_0093};
        vecs[2].n = 12; vecs[2].nw = 2; vecs[2].done = 1'b1; vecs[2].err = 1'b0;
        vecs[2].b = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
        vecs[2].w = '{32'h0000_0013, 32'h0010_0093};
        vecs[3].n = 7; vecs[3].nw = 0; vecs[3].done = 1'b1; vecs[3].err = 1'b0;
        vecs[3].b = '{8'hFF, 8'h00, 8'h3C, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[3].w = '{32'h0, 32'h0};
        vecs[4].n = 3; vecs[4].nw = 0; vecs[4].done = 1'b0; vecs[4].err = 1'b1;
        vecs[4].b = '{8'hA5, 8'h01, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[4].w = '{32'h0, 32'h0};

        // Reset state
        repeat (5) @(negedge sysclk);
        check_reset_outputs("reset_held");
        rst = 1'b0;
        repeat (5) @(negedge sysclk);
        check_reset_outputs("reset_released");

        // Table of frames
        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < vecs[v].n; i++) send_byte(vecs[v].b[i], 1'b1);
            repeat (4) @(negedge sysclk);
            check_status($sformatf("vec%0d", v), vecs[v].done, vecs[v].err);
            exp_w.delete();
            for (int i = 0; i < vecs[v].nw; i++) exp_w.push_back(vecs[v].w[i]);
            check_writes($sformatf("vec%0d", v), exp_w);
        end

        // Sync byte clears the sticky error, then an empty image completes
        send_byte(8'hA5, 1'b1);
        repeat (2) @(negedge sysclk);
        check_status("err_clear", 1'b0, 1'b0);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        repeat (2) @(negedge sysclk);
        check_status("err_clear_done", 1'b1, 1'b0);

        // Timeout inside DATA, checked just before and just after the limit
        fq = '{8'hA5, 8'h01, 8'h00, 8'h13, 8'h00};
        foreach (fq[i]) send_byte(fq[i], 1'b1);
        repeat (TMO - 100) @(negedge sysclk);
        check_status("tmo_before", 1'b0, 1'b0);
        repeat (110) @(negedge sysclk);
        check_status("tmo_after", 1'b0, 1'b1);
        exp_w.delete();
        check_writes("tmo", exp_w);

        // Framing error during DATA
        fq = '{8'hA5, 8'h01, 8'h00, 8'h13};
        foreach (fq[i]) send_byte(fq[i], 1'b1);
        check_status("ferr_before", 1'b0, 1'b0);
        send_byte(8'h00, 1'b0);
        repeat (2) @(negedge sysclk);
        check_status("ferr_after", 1'b0, 1'b1);
        check_writes("ferr", exp_w);

        // Reset mid-word, part-way through a byte
        fq = '{8'hA5, 8'h01, 8'h00, 8'h13, 8'h00};
        foreach (fq[i]) send_byte(fq[i], 1'b1);
        @(negedge sysclk);
        uart_rx = 1'b0;
        repeat (3 * CPB) @(negedge sysclk);
        rst = 1'b1;
        uart_rx = 1'b1;
        repeat (2) @(negedge sysclk);
        check_reset_outputs("midrst_held");
        rst = 1'b0;
        repeat (2 * CPB) @(negedge sysclk);
        check_reset_outputs("midrst_after");
        check_writes("midrst", exp_w);

        // Clean frame after reset lands at address 0
        fq = '{8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22};
        foreach (fq[i]) send_byte(fq[i], 1'b1);
        repeat (2) @(negedge sysclk);
        check_status("post_rst", 1'b1, 1'b0);
        exp_w = '{32'hDEAD_BEEF};
        check_writes("post_rst", exp_w);

        // Random frames against a frame-level model
        for (int t = 0; t < 6; t++) begin
            int          nwords;
            int          njunk;
            logic        corrupt;
            logic [31:0] wv;
            nwords  = $urandom_range(1, 4);
            njunk   = $urandom_range(0, 2);
            corrupt = 1'($urandom_range(0, 1));
            exp_w.delete();
            fq.delete();
            cs = 8'h00;
            for (int j = 0; j < njunk; j++) begin
                logic [7:0] jb;
                jb = 8'($urandom_range(0, 255));
                if (jb == 8'hA5) jb = 8'h5A;
                fq.push_back(jb);
            end
            fq.push_back(8'hA5);
            fq.push_back(8'(nwords));
            fq.push_back(8'h00);
            for (int k = 0; k < nwords; k++) begin
                wv = $urandom;
                exp_w.push_back(wv);
                for (int m = 0; m < 4; m++) begin
                    fq.push_back(wv[8*m +: 8]);
                    cs = cs ^ wv[8*m +: 8];
                end
            end
            if (corrupt) fq.push_back(cs ^ (8'h01 << $urandom_range(0, 7)));
            else         fq.push_back(cs);
            foreach (fq[i]) begin
                send_byte(fq[i], 1'b1);
                repeat ($urandom_range(0, 20)) @(negedge sysclk);
            end
            repeat (2) @(negedge sysclk);
            check_status($sformatf("rand%0d", t), ~corrupt, corrupt);
            check_writes($sformatf("rand%0d", t), exp_w);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule : tb_uart_program_loader
`default_nettype wire

// File: doc/uart_program_loader.md
# uart_program_loader

- Receives a program image over a UART line and writes it word by word into the CPU's program memory.
- Holds the CPU core in reset for the whole transfer and releases it once the image is verified.
- Sits directly upstream of the CPU: it drives the program-memory write port (`wr_addr`, `ram_in`, `byte_w_en`) and the core's reset input.

## Interface

Synchronisation and reset: one clock; reset is synchronous and active-high (ports `sysclk`, `rst`).

Parameters:
- `CLKS_PER_BIT`, default 868: `sysclk` cycles per UART bit (100 MHz / 115200).
- `PMEM_ADDR_WIDTH`, default 12: program-memory word-address width.
- `TIMEOUT_CYCLES`, default 1_000_000: allowed idle gap between bytes once a transfer has started.

Ports:
- `sysclk`  in  1: system clock.
- `rst`  in  1: synchronous, active-high reset.
- `uart_rx`  in  1: asynchronous serial input, 8N1, idles high.
- `pmem_wr_addr`  out  PMEM_ADDR_WIDTH: word address to write.
- `pmem_wr_data`  out  32: little-endian assembled word.
- `pmem_byte_w_en`  out  4: `4'b1111` for exactly one cycle per word, else `0`.
- `cpu_rst`  out  1: reset to the CPU core; high while not DONE.
- `load_done`  out  1: high in DONE.
- `load_error`  out  1: sticky error flag, cleared by the next sync byte or by `rst`.

## Operation

- Frame format: sync byte `0xA5`, then `LEN_LO`, `LEN_HI` (word count N, little-endian), then 4·N data bytes (LSB first per word), then one checksum byte.
- The checksum is the XOR of all 4·N data bytes; when N = 0 it is `0x00`.
- FSM states: IDLE, LEN0, LEN1, DATA, CHECK, DONE, ERROR.
- IDLE: bytes other than `0xA5` are discarded. `0xA5` moves to LEN0, clears `load_error`, and zeroes the address, byte index and checksum.
- LEN0 → LEN1 on the next byte, which stores `LEN_LO`.
- LEN1 stores `LEN_HI`, then:
  - N > 2^PMEM_ADDR_WIDTH → ERROR.
  - N = 0 → CHECK.
  - otherwise → DATA.
- DATA: each byte is shifted into the word at lane = byte index and XORed into the running checksum.
  - On the 4th byte, a write strobe is issued and the address increments.
  - After word N, the FSM moves to CHECK.
- CHECK: a received byte equal to the running checksum → DONE; otherwise → ERROR.
- DONE: `cpu_rst` = 0. A new `0xA5` restarts the load: `cpu_rst` = 1 and the FSM goes to LEN0. All other bytes are ignored.
- ERROR: `load_error` = 1 and `cpu_rst` = 1; the FSM behaves like IDLE (waits for `0xA5`).
- Receiver framing error (stop bit sampled low):
  - in any state other than IDLE or DONE → ERROR;
  - in IDLE or DONE → the byte is dropped.
- Timeout: in LEN0, LEN1, DATA or CHECK, if `TIMEOUT_CYCLES` pass with no completed byte → ERROR. The counter restarts on every byte.
- Memory already written before an error is not rolled back.

## Timing

- Reset values:
  - FSM = IDLE, `cpu_rst` = 1, `load_done` = 0, `load_error` = 0.
  - `pmem_byte_w_en` = 0, `pmem_wr_addr` = 0, `pmem_wr_data` = 0.
- `uart_rx` passes through a 2-flop synchroniser, adding 2 cycles of latency.
- Receiver timing:
  - A start bit is confirmed at mid-bit (CLKS_PER_BIT/2).
  - Data bits are sampled every CLKS_PER_BIT cycles, LSB first.
  - `byte_valid` pulses for 1 cycle at the mid-point of the stop bit.
- Write timing:
  - `pmem_byte_w_en` pulses the cycle after the `byte_valid` of each word's 4th byte.
  - `pmem_wr_addr` and `pmem_wr_data` are stable during that cycle.
  - The address increments the following cycle.
- Release timing: `cpu_rst` falls and `load_done` rises one cycle after the valid checksum byte's `byte_valid`.
- Address `2^PMEM_ADDR_WIDTH − 1` is the last legal write; the address counter never wraps within a frame.
- `rst` mid-transfer aborts the frame immediately: the receiver returns to idle and any partial byte or word is discarded.

## Structure

- A shared package holds:
  - state encodings;
  - the `SYNC_BYTE` constant `8'hA5`;
  - the `WORD_BYTES` constant (4).
- A natural sub-module is `uart_rx`:
  - contents: synchroniser, bit-timing counter, 8N1 shifter;
  - outputs: `rx_data[7:0]`, `byte_valid`, `frame_err`.
- The loader FSM, address, word and checksum registers, and timeout counter sit in the top module.

## Test plan

- Frame `A5 02 00 | 13 00 00 00 | 93 00 10 00 | checksum 0x90`:
  - writes `0x00000013` @0 and `0x00100093` @1, one strobe each;
  - then `cpu_rst` falls and `load_done` = 1.
- Same frame with checksum `0x91` → no release; `load_error` = 1 and `cpu_rst` stays 1.
- Then a corrected frame → `load_error` clears on `0xA5` and the load completes.
- Leading junk `FF 00 3C` before `A5 00 00 00` → no writes; DONE after the checksum `0x00`.
- `A5 01 00 13 00`, then silence for TIMEOUT_CYCLES + 10 → ERROR and no write strobe.
- A byte with its stop bit forced low during DATA → ERROR.
- Length `0x1001` with PMEM_ADDR_WIDTH = 12 → ERROR right after `LEN_HI`.
- `rst` asserted mid-word → all outputs at reset values.
- After `rst`, a clean frame loads correctly starting at address 0.
